exec_pipe_stager: RTL and testbench

EXEC_PIPE_STAGER -- requirements
Module: exec_pipe_stager

---
 rtl/exec_pipe_stager_if.sv | 39 +++
 rtl/exec_pipe_stager.sv | 120 ++++++++++++
 tb/tb_exec_pipe_stager.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/exec_pipe_stager_if.sv
// Bundle of issue, control and observation signals for exec_pipe_stager.
// The master side drives issue/stall/flush; the slave (the pipe) drives
// stage contents, forwarding readiness, write-back and the latency error.
interface exec_pipe_stager_if #(
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 7,
  parameter int LAT_W     = 4,
  parameter int DEPTH     = 7,
  parameter int NUM_UNITS = 4
);
  localparam int PK_W = 3 + DATA_W + ADDR_W + LAT_W + 1;

  logic                        issue_valid;
  logic [2:0]                  unit_id;
  logic [NUM_UNITS*DATA_W-1:0] unit_results;
  logic [ADDR_W-1:0]           reg_dst;
  logic [LAT_W-1:0]            latency;
  logic                        reg_wr;
  logic                        stall;
  logic                        flush;

  logic [DEPTH*PK_W-1:0]       stage_packed;
  logic [DEPTH-1:0]            stage_valid;
  logic [DEPTH-1:0]            stage_fwd_ready;
  logic [ADDR_W-1:0]           wb_addr;
  logic [DATA_W-1:0]           wb_data;
  logic                        wb_en;
  logic                        lat_err;

  modport master (
    output issue_valid, unit_id, unit_results, reg_dst, latency, reg_wr, stall, flush,
    input  stage_packed, stage_valid, stage_fwd_ready, wb_addr, wb_data, wb_en, lat_err
  );

  modport slave (
    input  issue_valid, unit_id, unit_results, reg_dst, latency, reg_wr, stall, flush,
    output stage_packed, stage_valid, stage_fwd_ready, wb_addr, wb_data, wb_en, lat_err
  );
endinterface

// File: rtl/exec_pipe_stager.sv
// exec_pipe_stager: fixed-depth result staging pipe between the execution
// units and the register file write-back port. Each stage carries a packed
// entry {unit_id, result, reg_dst, latency, reg_wr}; entries advance one
// stage per non-stalled cycle and retire through a registered write-back.
// Build option: define EXEC_PIPE_FLUSH_EN to make the flush input kill the
// youngest FLUSH_STAGES entries; without it flush is ignored.
module exec_pipe_stager #(
  parameter int DATA_W       = 128,
  parameter int ADDR_W       = 7,
  parameter int LAT_W        = 4,
  parameter int DEPTH        = 7,
  parameter int NUM_UNITS    = 4,
  parameter int FLUSH_STAGES = 2
) (
  input logic                clk,
  input logic                rst,
  exec_pipe_stager_if.slave  bus
);
  localparam int PK_W = 3 + DATA_W + ADDR_W + LAT_W + 1;

  // Field offsets inside a packed entry (reg_wr sits at bit 0).
  localparam int LAT_LSB  = 1;
  localparam int DST_LSB  = LAT_LSB + LAT_W;
  localparam int DATA_LSB = DST_LSB + ADDR_W;

  logic [PK_W-1:0]   stage_q [DEPTH];
  logic [PK_W-1:0]   stage_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic              wb_en_q, wb_en_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              lat_err_q, lat_err_d;

  logic [DATA_W-1:0] sel_result;
  logic [PK_W-1:0]   new_entry;
  logic              flush_eff;

`ifdef EXEC_PIPE_FLUSH_EN
  assign flush_eff = bus.flush;
`else
  assign flush_eff = 1'b0;
`endif

  // Form the incoming entry; an out-of-range unit selects an all-zero result.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel_result = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (bus.unit_id == 3'(u)) sel_result = bus.unit_results[(NUM_UNITS-1-u)*DATA_W +: DATA_W];
    end
    new_entry = {bus.unit_id, sel_result, bus.reg_dst, bus.latency, bus.reg_wr};
  end

  // Next state: shift on non-stall, kill young stages on flush, retire stage DEPTH.
  always_comb begin
    stage_d   = stage_q;
    valid_d   = valid_q;
    wb_en_d   = wb_en_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    lat_err_d = lat_err_q;
    if (!bus.stall) begin
      stage_d[0] = new_entry;
      valid_d[0] = bus.issue_valid;
      for (int k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
      // Killed stages keep their shifted data; only the valid bit drops.
      if (flush_eff) begin
        for (int k = 0; k < FLUSH_STAGES; k++) valid_d[k] = 1'b0;
      end
      wb_en_d = valid_q[DEPTH-1] & stage_q[DEPTH-1][0];
      if (wb_en_d) begin
        wb_addr_d = stage_q[DEPTH-1][DST_LSB +: ADDR_W];
        wb_data_d = stage_q[DEPTH-1][DATA_LSB +: DATA_W];
      end
      if (bus.issue_valid && ({{(32-LAT_W){1'b0}}, bus.latency} > 32'(DEPTH))) lat_err_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst) begin
      // NOTE: stage data is reset too, because stage_packed must read zero after reset.
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      valid_q   <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      lat_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= stage_d[k];
      valid_q   <= valid_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      lat_err_q <= lat_err_d;
    end
  end

  // Output view: stage 1 in the MSB slice; forwardable once stage >= max(latency, 1).
  always_comb begin
    bus.stage_packed    = '0;
    bus.stage_fwd_ready = '0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.stage_packed[(DEPTH-1-k)*PK_W +: PK_W] = stage_q[k];
      // Latency 0 passes this compare at every stage, which matches treating it as 1.
      bus.stage_fwd_ready[k] = valid_q[k] &
        ({{(32-LAT_W){1'b0}}, stage_q[k][LAT_LSB +: LAT_W]} <= 32'(k + 1));
    end
  end

  assign bus.stage_valid = valid_q;
  assign bus.wb_en       = wb_en_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.lat_err     = lat_err_q;
endmodule

// File: tb/tb_exec_pipe_stager.sv
// Self-checking bench for exec_pipe_stager. Every issued instruction is pushed
// to a scoreboard queue; each queue item tracks its own stage position and
// flush status and is popped when it should reach the write-back port.
module tb_exec_pipe_stager;
  localparam int DATA_W       = 128;
  localparam int ADDR_W       = 7;
  localparam int LAT_W        = 4;
  localparam int DEPTH        = 7;
  localparam int NUM_UNITS    = 4;
  localparam int FLUSH_STAGES = 2;
  localparam int PK_W         = 3 + DATA_W + ADDR_W + LAT_W + 1;

`ifdef EXEC_PIPE_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exec_pipe_stager_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LAT_W(LAT_W),
                        .DEPTH(DEPTH), .NUM_UNITS(NUM_UNITS)) bus ();

  exec_pipe_stager #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LAT_W(LAT_W), .DEPTH(DEPTH),
                     .NUM_UNITS(NUM_UNITS), .FLUSH_STAGES(FLUSH_STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]        unit;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] dst;
    logic [LAT_W-1:0]  lat;
    logic              wr;
    int                stg;
    bit                alive;
  } item_t;

  item_t             exp_q[$];
  logic [DATA_W-1:0] unit_val [NUM_UNITS];
  int                checks   = 0;
  int                failures = 0;
  logic              exp_en;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              exp_lat_err;

  task automatic check(input string tag, input logic [PK_W-1:0] act, input logic [PK_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] result_of(input int unit);
    return (unit < NUM_UNITS) ? unit_val[unit] : '0;
  endfunction

  // Compare every observable output against the scoreboard's view.
  task automatic compare_outputs();
    logic [DEPTH-1:0] ev;
    logic [DEPTH-1:0] ef;
    int               eff;
    ev = '0;
    ef = '0;
    foreach (exp_q[i]) begin
      if (exp_q[i].alive && exp_q[i].stg >= 1 && exp_q[i].stg <= DEPTH) begin
        ev[exp_q[i].stg-1] = 1'b1;
        eff = (exp_q[i].lat == 0) ? 1 : int'(exp_q[i].lat);
        if (eff <= exp_q[i].stg) ef[exp_q[i].stg-1] = 1'b1;
        check($sformatf("stage%0d_entry", exp_q[i].stg),
              bus.stage_packed[(DEPTH-exp_q[i].stg)*PK_W +: PK_W],
              {exp_q[i].unit, exp_q[i].data, exp_q[i].dst, exp_q[i].lat, exp_q[i].wr});
      end
    end
    check("stage_valid", bus.stage_valid, ev);
    check("fwd_ready", bus.stage_fwd_ready, ef);
    check("wb_en", bus.wb_en, exp_en);
    check("wb_addr", bus.wb_addr, exp_addr);
    check("wb_data", bus.wb_data, exp_data);
    check("lat_err", bus.lat_err, exp_lat_err);
  endtask

  // One clock of stimulus; the scoreboard advances alongside the DUT.
  task automatic step(input bit iv, input int unit, input int dst, input int lat,
                      input bit wr, input bit st, input bit fl);
    item_t it;
    rst              = 1'b1;
    bus.issue_valid  = iv;
    bus.unit_id      = 3'(unit);
    bus.reg_dst      = ADDR_W'(dst);
    bus.latency      = LAT_W'(lat);
    bus.reg_wr       = wr;
    bus.stall        = st;
    bus.flush        = fl;
    if (iv && !st) begin
      it = '{unit: 3'(unit), data: result_of(unit), dst: ADDR_W'(dst), lat: LAT_W'(lat),
             wr: wr, stg: 0, alive: 1'b1};
      exp_q.push_back(it);
      if (lat > DEPTH) exp_lat_err = 1'b1;
    end
    @(posedge clk);
    if (!st) begin
      foreach (exp_q[i]) begin
        if (FLUSH_ON && fl && exp_q[i].stg < FLUSH_STAGES) exp_q[i].alive = 1'b0;
        exp_q[i].stg++;
      end
      exp_en = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].stg == DEPTH + 1) begin
        it = exp_q.pop_front();
        if (it.alive && it.wr) begin
          exp_en   = 1'b1;
          exp_addr = it.dst;
          exp_data = it.data;
        end
      end
    end
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset with stall, flush and issue all asserted: reset must win.
  task automatic do_reset();
    rst             = 1'b0;
    bus.issue_valid = 1'b1;
    bus.unit_id     = 3'd1;
    bus.reg_dst     = 7'd99;
    bus.latency     = 4'd15;
    bus.reg_wr      = 1'b1;
    bus.stall       = 1'b1;
    bus.flush       = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_en      = 1'b0;
    exp_addr    = '0;
    exp_data    = '0;
    exp_lat_err = 1'b0;
    for (int k = 1; k <= DEPTH; k++)
      check($sformatf("rst_stage%0d", k), bus.stage_packed[(DEPTH-k)*PK_W +: PK_W], '0);
    compare_outputs();
  endtask

  initial begin
    bus.issue_valid  = 1'b0;
    bus.unit_id      = '0;
    bus.reg_dst      = '0;
    bus.latency      = '0;
    bus.reg_wr       = 1'b0;
    bus.stall        = 1'b0;
    bus.flush        = 1'b0;
    unit_val[0]      = {16{8'hA5}};
    unit_val[1]      = {4{32'h0123_4567}};
    unit_val[2]      = {$urandom, $urandom, $urandom, $urandom};
    unit_val[3]      = {2{64'hDEAD_BEEF_CAFE_F00D}};
    bus.unit_results = {unit_val[0], unit_val[1], unit_val[2], unit_val[3]};

    do_reset();
    idle(1);

    // Single issue, unit 0, dst 5, latency 2.
    step(1, 0, 5, 2, 1, 0, 0);
    idle(DEPTH + 2);

    // Back-to-back dst 1..7, latency 3; dst 6 selects a nonexistent unit.
    for (int d = 1; d <= 7; d++) step(1, (d == 6) ? 6 : (d - 1) % NUM_UNITS, d, 3, 1, 0, 0);
    idle(DEPTH + 2);

    // dst 9 stalled for three cycles at stage 4; issue during stall is ignored.
    step(1, 1, 9, 2, 1, 0, 0);
    idle(3);
    step(1, 2, 30, 2, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 3, 31, 1, 1, 1, 1);
    idle(DEPTH + 1);

    // Flush on the cycle dst 3 issues: dst 2 and dst 3 die, older dst 4 retires.
    step(1, 0, 4, 1, 1, 0, 0);
    idle(2);
    step(1, 1, 2, 1, 1, 0, 0);
    step(1, 2, 3, 1, 1, 0, 1);
    idle(DEPTH + 2);

    // Illegal latency sets a sticky error but still writes back; lat 0 and reg_wr 0.
    step(1, 3, 12, 12, 1, 0, 0);
    step(1, 2, 13, 0, 1, 0, 0);
    step(1, 1, 14, 5, 0, 0, 0);
    idle(DEPTH + 2);

    // Reset with entries in stages 3 and 6 discards them and clears lat_err.
    step(1, 0, 20, 2, 1, 0, 0);
    idle(2);
    step(1, 1, 21, 2, 1, 0, 0);
    idle(2);
    do_reset();
    idle(2);

    // Normal operation resumes after reset.
    step(1, 2, 22, 4, 1, 0, 0);
    idle(DEPTH + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
